// File: rtl/stage_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// stage_sequencer_pkg
// Shared types and helpers for the stage sequencer:
//   seq_state_t : sequencer state encoding (IDLE, CMD, RUN, DONE)
//   pass_len()  : number of serial cycles in one pass (narrow or wide)
// ----------------------------------------------------------------------------
package stage_sequencer_pkg;

  typedef enum logic [1:0] {
    SEQ_ST_IDLE = 2'd0,
    SEQ_ST_CMD  = 2'd1,
    SEQ_ST_RUN  = 2'd2,
    SEQ_ST_DONE = 2'd3
  } seq_state_t;

  // A wide pass moves a double-width operand through the NSHIFT-bit datapath.
  function automatic int pass_len(input int reg_bits, input int nshift, input logic wide);
    return wide ? (2 * reg_bits) / nshift : reg_bits / nshift;
  endfunction

endpackage

// File: rtl/stage_sequencer_pass_counter.sv
// ----------------------------------------------------------------------------
// stage_sequencer_pass_counter
// Holds the in-pass cycle counter and the completed-pass count of the current
// stage.
//   clk, reset : clock, asynchronous active-low reset
//   load       : start of an instruction, clears counter and pass
//   advance    : one serial cycle executed
//   wide       : selects the long pass length
//   pass_inc   : on wrap, count another pass of the same stage (else clear)
//   wrap       : counter is on the final cycle of the pass
//   counter    : cycle within the pass
//   pass       : passes completed in the current stage
// ----------------------------------------------------------------------------
module stage_sequencer_pass_counter
  import stage_sequencer_pkg::*;
#(
  parameter int NSHIFT      = 2,
  parameter int REG_BITS    = 8,
  parameter int REPEAT_BITS = 3
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   load,
  input  logic                                   advance,
  input  logic                                   wide,
  input  logic                                   pass_inc,
  output logic                                   wrap,
  output logic [$clog2(2*REG_BITS/NSHIFT)-1:0]   counter,
  output logic [REPEAT_BITS-1:0]                 pass
);

  assign wrap = (int'(counter) == pass_len(REG_BITS, NSHIFT, wide) - 1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      counter <= '0;
      pass    <= '0;
    end else if (load) begin
      counter <= '0;
      pass    <= '0;
    end else if (advance) begin
      if (wrap) begin
        counter <= '0;
        // Moving to a new stage starts its pass count from zero.
        pass    <= pass_inc ? pass + 1'b1 : '0;
      end else begin
        counter <= counter + 1'b1;
      end
    end
  end

endmodule

// File: rtl/stage_sequencer.sv
// ----------------------------------------------------------------------------
// stage_sequencer
// Steps one instruction through up to NUM_STAGES bit-serial stages. Each
// masked stage runs (1 + stage_repeat[i]) passes; a pass may first issue a TX
// command and may be paced by TX data consumption and RX data arrival.
// Outstanding read commands are counted in reads_pending.
//   clk, reset            : clock, asynchronous active-low reset
//   inst_valid, stage_*   : instruction and per-stage controls, held until inst_done
//   wide                  : long pass length
//   ext_wait, abort       : external stall, synchronous cancel
//   tx_command_*          : command handshake towards TX
//   tx_data_next          : TX consumes data this cycle
//   rx_data_valid, rx_done: reply data present / last reply cycle
//   stage, pass, counter  : position within the instruction
//   advance, first_cycle, last_cycle : ALU enable and pass boundary markers
//   inst_done             : one-cycle completion pulse
//   reads_pending         : outstanding read commands
// ----------------------------------------------------------------------------
module stage_sequencer
  import stage_sequencer_pkg::*;
#(
  parameter int NSHIFT      = 2,
  parameter int REG_BITS    = 8,
  parameter int NUM_STAGES  = 4,
  parameter int REPEAT_BITS = 3,
  parameter int MAX_READS   = 2
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  inst_valid,
  input  logic [NUM_STAGES-1:0]                 stage_mask,
  input  logic [NUM_STAGES*REPEAT_BITS-1:0]     stage_repeat,
  input  logic [NUM_STAGES-1:0]                 stage_send,
  input  logic [NUM_STAGES-1:0]                 stage_read,
  input  logic [NUM_STAGES-1:0]                 stage_wait_rx,
  input  logic                                  wide,
  input  logic                                  ext_wait,
  input  logic                                  abort,
  output logic                                  tx_command_valid,
  output logic                                  tx_command_is_read,
  input  logic                                  tx_command_started,
  input  logic                                  tx_data_next,
  input  logic                                  rx_data_valid,
  input  logic                                  rx_done,
  output logic [$clog2(NUM_STAGES)-1:0]         stage,
  output logic [REPEAT_BITS-1:0]                pass,
  output logic [$clog2(2*REG_BITS/NSHIFT)-1:0]  counter,
  output logic                                  advance,
  output logic                                  first_cycle,
  output logic                                  last_cycle,
  output logic                                  inst_done,
  output logic [$clog2(MAX_READS+1)-1:0]        reads_pending
);

  localparam int STAGE_W = $clog2(NUM_STAGES);
  localparam int RD_W    = $clog2(MAX_READS + 1);
  localparam logic [RD_W-1:0] READS_FULL = RD_W'(MAX_READS);

  seq_state_t         state, state_d;
  logic [STAGE_W-1:0] stage_d, first_idx, next_idx;
  logic               first_found, next_found;
  logic [RD_W-1:0]    pending_d;
  logic               valid_d, is_read_d, done_d;
  logic               load, wrap, pass_inc, stall, cmd_fire, read_fire;
  logic [REPEAT_BITS-1:0] repeat_cur;

  assign repeat_cur = stage_repeat[int'(stage)*REPEAT_BITS +: REPEAT_BITS];
  assign pass_inc   = (pass < repeat_cur);

  assign stall = ext_wait
               | (stage_wait_rx[stage] & ~rx_data_valid)
               | (stage_send[stage] & ~tx_data_next);

  assign advance     = (state == SEQ_ST_RUN) & ~stall;
  assign first_cycle = advance & (counter == '0);
  assign last_cycle  = advance & wrap;

  assign cmd_fire  = (state == SEQ_ST_CMD) & tx_command_valid & tx_command_started;
  assign read_fire = cmd_fire & stage_read[stage] & (reads_pending != READS_FULL);

  // Lowest set mask bit overall, and lowest set bit above the current stage.
  // The loop runs downwards so the last hit is the lowest index.
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    next_found  = 1'b0;
    next_idx    = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (stage_mask[i]) begin
        first_found = 1'b1;
        first_idx   = STAGE_W'(i);
      end
      if (stage_mask[i] && (i > int'(stage))) begin
        next_found = 1'b1;
        next_idx   = STAGE_W'(i);
      end
    end
  end

  // NOTE: every variable written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d = state;
    stage_d = stage;
    load    = 1'b0;
    done_d  = 1'b0;
    if (abort) begin
      state_d = SEQ_ST_IDLE;
    end else begin
      unique case (state)
        SEQ_ST_IDLE: begin
          if (inst_valid) begin
            load = 1'b1;
            if (first_found) begin
              stage_d = first_idx;
              state_d = stage_send[first_idx] ? SEQ_ST_CMD : SEQ_ST_RUN;
            end else begin
              state_d = SEQ_ST_DONE;
              done_d  = 1'b1;
            end
          end
        end
        SEQ_ST_CMD: begin
          if (cmd_fire) state_d = SEQ_ST_RUN;
        end
        SEQ_ST_RUN: begin
          if (advance && wrap) begin
            if (pass_inc) begin
              state_d = stage_send[stage] ? SEQ_ST_CMD : SEQ_ST_RUN;
            end else if (next_found) begin
              stage_d = next_idx;
              state_d = stage_send[next_idx] ? SEQ_ST_CMD : SEQ_ST_RUN;
            end else begin
              state_d = SEQ_ST_DONE;
              done_d  = 1'b1;
            end
          end
        end
        SEQ_ST_DONE: state_d = SEQ_ST_IDLE;
        default:     state_d = SEQ_ST_IDLE;
      endcase
    end
  end

  // Read accounting ignores abort so replies to cancelled reads still drain it.
  always_comb begin
    pending_d = reads_pending;
    if (read_fire && !rx_done)
      pending_d = reads_pending + 1'b1;
    else if (rx_done && !read_fire && (reads_pending != '0))
      pending_d = reads_pending - 1'b1;
  end

  // The command request is registered, so it is computed from next-cycle state.
  assign is_read_d = (state_d == SEQ_ST_CMD) & stage_read[stage_d];
  assign valid_d   = (state_d == SEQ_ST_CMD) & ~ext_wait
                   & ~(stage_read[stage_d] & (pending_d == READS_FULL));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state              <= SEQ_ST_IDLE;
      stage              <= '0;
      inst_done          <= 1'b0;
      tx_command_valid   <= 1'b0;
      tx_command_is_read <= 1'b0;
      reads_pending      <= '0;
    end else begin
      state              <= state_d;
      stage              <= stage_d;
      inst_done          <= done_d;
      tx_command_valid   <= valid_d;
      tx_command_is_read <= is_read_d;
      reads_pending      <= pending_d;
    end
  end

  stage_sequencer_pass_counter #(
    .NSHIFT      (NSHIFT),
    .REG_BITS    (REG_BITS),
    .REPEAT_BITS (REPEAT_BITS)
  ) u_pass_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .advance  (advance),
    .wide     (wide),
    .pass_inc (pass_inc),
    .wrap     (wrap),
    .counter  (counter),
    .pass     (pass)
  );

endmodule

// File: tb/tb_stage_sequencer.sv
// ----------------------------------------------------------------------------
// tb_stage_sequencer
// Self-checking bench for stage_sequencer. The reference model expands each
// instruction into a queue of (stage, pass) entries and consumes one entry per
// L advances, tracking outstanding reads as a plain integer.
// ----------------------------------------------------------------------------
module tb_stage_sequencer;

  localparam int NSHIFT = 2, REG_BITS = 8, NUM_STAGES = 4, REPEAT_BITS = 3, MAX_READS = 2;

  logic        clk = 1'b0, reset = 1'b0;
  logic        inst_valid = 1'b0;
  logic [3:0]  stage_mask = '0, stage_send = '0, stage_read = '0, stage_wait_rx = '0;
  logic [11:0] stage_repeat = '0;
  logic        wide = 1'b0, ext_wait = 1'b0, abort = 1'b0;
  logic        tx_command_started = 1'b0, tx_data_next = 1'b0, rx_data_valid = 1'b0, rx_done = 1'b0;
  logic        tx_command_valid, tx_command_is_read, advance, first_cycle, last_cycle, inst_done;
  logic [1:0]  stage, reads_pending;
  logic [2:0]  pass, counter;

  always #5 clk = ~clk;

  stage_sequencer #(
    .NSHIFT(NSHIFT), .REG_BITS(REG_BITS), .NUM_STAGES(NUM_STAGES),
    .REPEAT_BITS(REPEAT_BITS), .MAX_READS(MAX_READS)
  ) dut (
    .clk(clk), .reset(reset), .inst_valid(inst_valid), .stage_mask(stage_mask),
    .stage_repeat(stage_repeat), .stage_send(stage_send), .stage_read(stage_read),
    .stage_wait_rx(stage_wait_rx), .wide(wide), .ext_wait(ext_wait), .abort(abort),
    .tx_command_valid(tx_command_valid), .tx_command_is_read(tx_command_is_read),
    .tx_command_started(tx_command_started), .tx_data_next(tx_data_next),
    .rx_data_valid(rx_data_valid), .rx_done(rx_done), .stage(stage), .pass(pass),
    .counter(counter), .advance(advance), .first_cycle(first_cycle),
    .last_cycle(last_cycle), .inst_done(inst_done), .reads_pending(reads_pending)
  );

  typedef struct { int stg; int pas; } pass_t;

  // Reference model: phase 0 idle, 1 command, 2 running, 3 done.
  pass_t mq[$];
  int    m_phase = 0, m_cnt = 0, m_pend = 0;

  // Scenario knobs.
  bit         k_rand, k_rxd_with_start, k_use_pat;
  int         k_start_delay, k_rx_mode, k_rxd_at, k_abort_at, k_stop_at;
  logic [2:0] k_rx_pat;

  // Per-instruction observations.
  int adv_count, vhold, blocked;
  int seq_log[$];

  int n_checks = 0, n_pass = 0;

  task automatic set_defaults();
    stage_mask = '0; stage_repeat = '0; stage_send = '0; stage_read = '0;
    stage_wait_rx = '0; wide = 1'b0;
    k_rand = 0; k_rxd_with_start = 0; k_use_pat = 0; k_rx_pat = '0;
    k_start_delay = 0; k_rx_mode = 0; k_rxd_at = -1; k_abort_at = -1; k_stop_at = -1;
  endtask

  task automatic build_model();
    mq.delete();
    for (int s = 0; s < NUM_STAGES; s++)
      if (stage_mask[s])
        for (int p = 0; p <= int'(stage_repeat[s*REPEAT_BITS +: REPEAT_BITS]); p++)
          mq.push_back('{stg: s, pas: p});
  endtask

  // Drives one instruction cycle by cycle and compares every output to the
  // model. Called at posedge+1; returns at posedge+1.
  task automatic run_inst(input int max_cyc);
    int cyc = 0, vdel = 0, rx_idx = 0, cur, len;
    bit done_seen = 0, aborted = 0, finished = 0, exp_valid, exp_adv, stall, fire, rd_inc;
    adv_count = 0; vhold = 0; blocked = 0; seq_log.delete();
    len = wide ? 2*REG_BITS/NSHIFT : REG_BITS/NSHIFT;
    while (!finished && cyc < max_cyc) begin
      if (k_stop_at >= 0 && cyc == k_stop_at) begin
        finished = 1;
      end else begin
        cur = (mq.size() > 0) ? mq[0].stg : 0;
        exp_valid = (m_phase == 1) && !(stage_read[cur] && m_pend == MAX_READS);
        n_checks++;
        if (tx_command_valid !== exp_valid) $display("FAIL tx_command_valid cyc %0d: got %b expected %b", cyc, tx_command_valid, exp_valid);
        else n_pass++;
        n_checks++;
        if (tx_command_is_read !== ((m_phase == 1) && stage_read[cur])) $display("FAIL tx_command_is_read cyc %0d: got %b", cyc, tx_command_is_read);
        else n_pass++;
        n_checks++;
        if (inst_done !== (m_phase == 3)) $display("FAIL inst_done cyc %0d: got %b expected %b", cyc, inst_done, m_phase == 3);
        else n_pass++;
        n_checks++;
        if (int'(reads_pending) != m_pend) $display("FAIL reads_pending cyc %0d: got %0d expected %0d", cyc, reads_pending, m_pend);
        else n_pass++;
        if (m_phase == 1 || m_phase == 2) begin
          n_checks++;
          if (int'(stage) != cur || int'(pass) != mq[0].pas || int'(counter) != m_cnt)
            $display("FAIL position cyc %0d: got stage %0d pass %0d counter %0d expected %0d %0d %0d",
                     cyc, stage, pass, counter, cur, mq[0].pas, m_cnt);
          else n_pass++;
        end
        if (m_phase == 3) done_seen = 1;

        // Stimulus for this cycle.
        inst_valid = !done_seen && !aborted;
        abort = (cyc == k_abort_at);
        if (abort) begin aborted = 1; inst_valid = 1'b0; end
        if (k_rand) begin
          // ext_wait is kept low on any cycle that may enter the command phase.
          ext_wait      = (m_phase == 2 && m_cnt != len - 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
          rx_data_valid = $urandom_range(0, 1) == 1;
          tx_data_next  = $urandom_range(0, 3) != 0;
        end else begin
          ext_wait = 1'b0; tx_data_next = 1'b1; rx_data_valid = 1'b1;
          if (k_use_pat && m_phase == 2 && rx_idx < 3) begin
            rx_data_valid = k_rx_pat[rx_idx];
            rx_idx++;
          end
        end
        tx_command_started = 1'b0;
        if (m_phase == 1 && tx_command_valid) begin
          if (k_start_delay < 0 ? ($urandom_range(0, 2) == 0) : (vdel >= k_start_delay)) begin
            tx_command_started = 1'b1; vdel = 0;
          end else vdel++;
        end
        rx_done = 1'b0;
        if (m_pend > 0) begin
          if (k_rx_mode == 1 && $urandom_range(0, 3) == 0) rx_done = 1'b1;
          if (cyc == k_rxd_at) rx_done = 1'b1;
          if (k_rxd_with_start && tx_command_started) rx_done = 1'b1;
        end
        #1;
        stall   = ext_wait || (stage_wait_rx[cur] && !rx_data_valid) || (stage_send[cur] && !tx_data_next);
        exp_adv = (m_phase == 2) && !stall;
        n_checks++;
        if (advance !== exp_adv) $display("FAIL advance cyc %0d: got %b expected %b", cyc, advance, exp_adv);
        else n_pass++;
        n_checks++;
        if (first_cycle !== (exp_adv && m_cnt == 0) || last_cycle !== (exp_adv && m_cnt == len - 1))
          $display("FAIL first_last cyc %0d: got %b%b expected %b%b", cyc, first_cycle, last_cycle,
                   exp_adv && m_cnt == 0, exp_adv && m_cnt == len - 1);
        else n_pass++;
        if (advance) adv_count++;
        if (first_cycle) seq_log.push_back(int'(stage));
        if (m_phase == 1 && tx_command_valid && !tx_command_started) vhold++;
        if (m_phase == 1 && !tx_command_valid) blocked++;

        // Model update for the coming edge.
        fire   = (m_phase == 1) && exp_valid && tx_command_started;
        rd_inc = fire && stage_read[cur];
        if (rd_inc && !rx_done) m_pend++;
        else if (rx_done && !rd_inc && m_pend > 0) m_pend--;
        if (abort) begin
          m_phase = 0;
        end else begin
          case (m_phase)
            0: if (inst_valid) begin
                 build_model();
                 m_cnt = 0;
                 if (mq.size() == 0) m_phase = 3;
                 else m_phase = stage_send[mq[0].stg] ? 1 : 2;
               end
            1: if (fire) m_phase = 2;
            2: if (exp_adv) begin
                 m_cnt++;
                 if (m_cnt == len) begin
                   m_cnt = 0;
                   void'(mq.pop_front());
                   if (mq.size() == 0) m_phase = 3;
                   else m_phase = stage_send[mq[0].stg] ? 1 : 2;
                 end
               end
            default: m_phase = 0;
          endcase
        end
        @(posedge clk); #1;
        cyc++;
        if (done_seen && m_phase == 0) finished = 1;
        if (aborted && cyc >= k_abort_at + 3) finished = 1;
      end
    end
    n_checks++;
    if (!finished) $display("FAIL timeout: instruction still running after %0d cycles, expected completion", cyc);
    else n_pass++;
    inst_valid = 1'b0; abort = 1'b0; tx_command_started = 1'b0; rx_done = 1'b0; ext_wait = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2;
    n_checks++;
    if ({tx_command_valid, tx_command_is_read, stage, pass, counter, advance, first_cycle,
         last_cycle, inst_done, reads_pending} !== '0)
      $display("FAIL reset_outputs: got %b expected all zero", {tx_command_valid, tx_command_is_read,
               stage, pass, counter, advance, first_cycle, last_cycle, inst_done, reads_pending});
    else n_pass++;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_wide();
    set_defaults();
    stage_mask = 4'b0010; wide = 1'b1;
    run_inst(40);
    n_checks++;
    if (adv_count != 8 || seq_log.size() != 1) $display("FAIL single_wide: got %0d advances %0d passes expected 8 1", adv_count, seq_log.size());
    else n_pass++;
  endtask

  task automatic test_multi_stage();
    int exp_seq[5] = '{0, 1, 3, 3, 3};
    set_defaults();
    stage_mask = 4'b1011; stage_repeat = {3'd2, 3'd0, 3'd0, 3'd0};
    run_inst(60);
    n_checks++;
    if (adv_count != 20) $display("FAIL multi_stage_advances: got %0d expected 20", adv_count);
    else n_pass++;
    n_checks++;
    if (seq_log.size() != 5) $display("FAIL multi_stage_passes: got %0d expected 5", seq_log.size());
    else begin
      bit ok = 1;
      for (int i = 0; i < 5; i++) if (seq_log[i] != exp_seq[i]) ok = 0;
      if (!ok) $display("FAIL multi_stage_sequence: got %p expected %p", seq_log, exp_seq);
      else n_pass++;
    end
  endtask

  task automatic test_read_handshake();
    set_defaults();
    stage_mask = 4'b0001; stage_send = 4'b0001; stage_read = 4'b0001; k_start_delay = 5;
    run_inst(60);
    n_checks++;
    if (vhold != 5) $display("FAIL read_valid_hold: got %0d cycles expected 5", vhold);
    else n_pass++;
    n_checks++;
    if (reads_pending !== 2'd1) $display("FAIL read_pending_up: got %0d expected 1", reads_pending);
    else n_pass++;
    rx_done = 1'b1; @(posedge clk); #1; rx_done = 1'b0; m_pend = 0;
    n_checks++;
    if (reads_pending !== 2'd0) $display("FAIL read_pending_down: got %0d expected 0", reads_pending);
    else n_pass++;
  endtask

  task automatic test_wait_rx();
    set_defaults();
    stage_mask = 4'b0001; stage_wait_rx = 4'b0001; k_use_pat = 1; k_rx_pat = 3'b101;
    run_inst(40);
    n_checks++;
    if (adv_count != 4) $display("FAIL wait_rx_advances: got %0d expected 4", adv_count);
    else n_pass++;
  endtask

  task automatic test_max_reads();
    set_defaults();
    stage_mask = 4'b0001; stage_send = 4'b0001; stage_read = 4'b0001;
    run_inst(40);
    run_inst(40);
    n_checks++;
    if (reads_pending !== 2'd2) $display("FAIL max_reads_full: got %0d expected 2", reads_pending);
    else n_pass++;
    k_rxd_at = 6; k_rxd_with_start = 1;
    run_inst(60);
    n_checks++;
    if (blocked != 6) $display("FAIL max_reads_blocked: got %0d cycles expected 6", blocked);
    else n_pass++;
    n_checks++;
    if (reads_pending !== 2'd1) $display("FAIL max_reads_simultaneous: got %0d expected 1", reads_pending);
    else n_pass++;
    rx_done = 1'b1; @(posedge clk); #1; rx_done = 1'b0; m_pend = 0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      set_defaults();
      stage_mask    = 4'($urandom_range(0, 15));
      stage_repeat  = 12'($urandom);
      stage_send    = 4'($urandom_range(0, 15));
      stage_read    = 4'($urandom_range(0, 15));
      stage_wait_rx = 4'($urandom_range(0, 15));
      wide          = $urandom_range(0, 1) == 1;
      k_rand = 1; k_start_delay = -1; k_rx_mode = 1;
      run_inst(4000);
    end
  endtask

  task automatic test_abort_and_reset();
    set_defaults();
    stage_mask = 4'b0001; wide = 1'b1; k_abort_at = 3;
    run_inst(30);
    set_defaults();
    stage_mask = 4'b0010; wide = 1'b1; k_stop_at = 4;
    run_inst(30);
    n_checks++;
    if (counter !== 3'd3) $display("FAIL pre_reset_counter: got %0d expected 3", counter);
    else n_pass++;
    inst_valid = 1'b1;
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({tx_command_valid, tx_command_is_read, stage, pass, counter, advance, first_cycle,
         last_cycle, inst_done, reads_pending} !== '0)
      $display("FAIL async_reset_outputs: got %b expected all zero", {tx_command_valid, tx_command_is_read,
               stage, pass, counter, advance, first_cycle, last_cycle, inst_done, reads_pending});
    else n_pass++;
    inst_valid = 1'b0; m_phase = 0; m_pend = 0; m_cnt = 0; mq.delete();
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    set_defaults();
    test_reset();
    test_single_wide();
    test_multi_stage();
    test_read_handshake();
    test_wait_rx();
    test_max_reads();
    test_random();
    test_abort_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
